// File: rtl/pad_turnaround_pkg.sv
// Shared types and helpers for the half-duplex pad turnaround sequencer.
package pad_turnaround_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    TURN   = 2'd2,
    SAMPLE = 2'd3
  } pad_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pad_turnaround_ctrl.sv
// Half-duplex pad sequencer: drives a write for DRIVE_CYC cycles, always releases
// the bank for TURN_CYC cycles afterwards, and samples reads after a turnaround gap.
module pad_turnaround_ctrl
  import pad_turnaround_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DRIVE_CYC = 2,
  parameter int unsigned TURN_CYC  = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic             rsp_write,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] pad_t,
  input  logic [WIDTH-1:0] pad_i
);

  localparam int unsigned CNT_MAX = max_u(DRIVE_CYC, TURN_CYC);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  pad_state_e       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             wr_q, wr_nxt;
  logic [WIDTH-1:0] wdata_q, wdata_nxt;

  logic             accept;
  logic             rsp_valid_d, rsp_write_d;
  logic [WIDTH-1:0] rsp_rdata_d, pad_o_d, pad_t_d;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // State, counter and request latch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_q    <= wr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  // Next state plus next values for the registered pad/response outputs
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wr_nxt      = wr_q;
    wdata_nxt   = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_rdata_d = rsp_rdata;

    unique case (state)
      IDLE: begin
        if (accept) begin
          wr_nxt    = req_write;
          wdata_nxt = req_wdata;
          if (req_write) begin
            state_nxt = DRIVE;
            cnt_nxt   = CW'(DRIVE_CYC);
          end else begin
            state_nxt = TURN;
            cnt_nxt   = CW'(TURN_CYC);
          end
        end
      end
      DRIVE: begin
        if (cnt == CW'(1)) begin
          state_nxt = TURN;
          cnt_nxt   = CW'(TURN_CYC);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      TURN: begin
        if (cnt == CW'(1)) begin
          if (wr_q) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
          end else begin
            state_nxt = SAMPLE;
            cnt_nxt   = CW'(1);
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      SAMPLE: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b0;
        rsp_rdata_d = pad_i;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Pads only leave the released state while the next state is DRIVE
    if (state_nxt == DRIVE) begin
      pad_t_d = '0;
      pad_o_d = wdata_nxt;
    end else begin
      pad_t_d = '1;
      pad_o_d = '0;
    end
  end

  // Registered pad and response outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pad_t     <= '1;
      pad_o     <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      pad_t     <= pad_t_d;
      pad_o     <= pad_o_d;
      rsp_valid <= rsp_valid_d;
      rsp_write <= rsp_write_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_pad_turnaround_ctrl.sv
// Directed bench for pad_turnaround_ctrl: default timing instance plus a 1/1 timing instance.
module tb_pad_turnaround_ctrl;

  logic clk;
  logic rstn;

  // Default instance (WIDTH=8, DRIVE_CYC=2, TURN_CYC=2)
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_write;
  logic [7:0] rsp_rdata, pad_o, pad_t, pad_i;

  // Short-timing instance (DRIVE_CYC=1, TURN_CYC=1)
  logic       v1, rdy1, w1;
  logic [7:0] wd1;
  logic       rv1, rw1;
  logic [7:0] rd1, po1, pt1, pi1;

  int tests_run    = 0;
  int tests_failed = 0;
  int acc;
  logic drv;

  pad_turnaround_ctrl #(.WIDTH(8), .DRIVE_CYC(2), .TURN_CYC(2)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .pad_o(pad_o), .pad_t(pad_t), .pad_i(pad_i)
  );

  pad_turnaround_ctrl #(.WIDTH(8), .DRIVE_CYC(1), .TURN_CYC(1)) dut1 (
    .clk(clk), .rstn(rstn),
    .req_valid(v1), .req_ready(rdy1), .req_write(w1), .req_wdata(wd1),
    .rsp_valid(rv1), .rsp_write(rw1), .rsp_rdata(rd1),
    .pad_o(po1), .pad_t(pt1), .pad_i(pi1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0; pad_i = '0;
    v1 = 1'b0; w1 = 1'b0; wd1 = '0; pi1 = '0;

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_pad_t", 32'(pad_t), 32'hFF);
    check("rst_pad_o", 32'(pad_o), 32'h00);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'h00);

    // Write 0xA5: drive cycles 1-2, turnaround 3-4, response cycle 5
    @(posedge clk); #1 req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'hA5;
    @(negedge clk);
    check("wr_ready_c0", 32'(req_ready), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1 if (c == 1) req_valid = 1'b0;
      @(negedge clk);
      drv = (c <= 2);
      check($sformatf("wr_pad_t_c%0d", c), 32'(pad_t), drv ? 32'h00 : 32'hFF);
      check($sformatf("wr_pad_o_c%0d", c), 32'(pad_o), drv ? 32'hA5 : 32'h00);
      check($sformatf("wr_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(c == 5));
      check($sformatf("wr_rsp_write_c%0d", c), 32'(rsp_write), 32'(c == 5));
      check($sformatf("wr_ready_c%0d", c), 32'(req_ready), 32'(c >= 5));
      check($sformatf("wr_rdata_c%0d", c), 32'(rsp_rdata), 32'h00);
    end

    // Read: pad_i=0x3C only in cycle 3 (SAMPLE), response cycle 4
    @(posedge clk); #1 req_valid = 1'b1; req_write = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1 if (c == 1) req_valid = 1'b0;
      pad_i = (c == 3) ? 8'h3C : 8'h00;
      @(negedge clk);
      check($sformatf("rd_pad_t_c%0d", c), 32'(pad_t), 32'hFF);
      check($sformatf("rd_pad_o_c%0d", c), 32'(pad_o), 32'h00);
      check($sformatf("rd_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(c == 4));
      check($sformatf("rd_rsp_write_c%0d", c), 32'(rsp_write), 32'd0);
      check($sformatf("rd_rdata_c%0d", c), 32'(rsp_rdata), (c >= 4) ? 32'h3C : 32'h00);
      check($sformatf("rd_ready_c%0d", c), 32'(req_ready), 32'(c >= 4));
    end

    // Write then read with req_valid held: read accepted in cycle 5, response cycle 9
    acc = 0;
    @(posedge clk); #1 req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h5F;
    @(negedge clk);
    if (req_valid && req_ready) acc++;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1
      if (c == 1) req_write = 1'b0;
      if (c == 6) req_valid = 1'b0;
      pad_i = (c == 8) ? 8'h5A : 8'h00;
      @(negedge clk);
      if (req_valid && req_ready) acc++;
      drv = (c <= 2);
      check($sformatf("b2b_pad_t_c%0d", c), 32'(pad_t), drv ? 32'h00 : 32'hFF);
      check($sformatf("b2b_pad_o_c%0d", c), 32'(pad_o), drv ? 32'h5F : 32'h00);
      check($sformatf("b2b_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(c == 5 || c == 9));
      check($sformatf("b2b_rsp_write_c%0d", c), 32'(rsp_write), 32'(c == 5));
      check($sformatf("b2b_ready_c%0d", c), 32'(req_ready), 32'(c == 5 || c >= 9));
      check($sformatf("b2b_rdata_c%0d", c), 32'(rsp_rdata), (c >= 9) ? 32'h5A : 32'h3C);
    end
    check("b2b_accepts", 32'(acc), 32'd2);

    // Asynchronous reset in cycle 1 of a DRIVE drops the write
    @(posedge clk); #1 req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'hC3;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("arst_pre_pad_t", 32'(pad_t), 32'h00);
    check("arst_pre_pad_o", 32'(pad_o), 32'hC3);
    #2 rstn = 1'b0;
    #1;
    check("arst_pad_t", 32'(pad_t), 32'hFF);
    check("arst_pad_o", 32'(pad_o), 32'h00);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rdata", 32'(rsp_rdata), 32'h00);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("arst_ready_after", 32'(req_ready), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("arst_no_rsp_c%0d", c), 32'(rsp_valid), 32'd0);
      check($sformatf("arst_pad_t_c%0d", c), 32'(pad_t), 32'hFF);
    end

    // Short timing: write 0x81 drives cycle 1, response cycle 3
    @(posedge clk); #1 v1 = 1'b1; w1 = 1'b1; wd1 = 8'h81;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1 if (c == 1) v1 = 1'b0;
      @(negedge clk);
      check($sformatf("s_wr_pad_t_c%0d", c), 32'(pt1), (c == 1) ? 32'h00 : 32'hFF);
      check($sformatf("s_wr_pad_o_c%0d", c), 32'(po1), (c == 1) ? 32'h81 : 32'h00);
      check($sformatf("s_wr_rsp_valid_c%0d", c), 32'(rv1), 32'(c == 3));
      check($sformatf("s_wr_rsp_write_c%0d", c), 32'(rw1), 32'(c == 3));
    end

    // Short timing: read samples pad_i in cycle 2, response cycle 3
    @(posedge clk); #1 v1 = 1'b1; w1 = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1 if (c == 1) v1 = 1'b0;
      pi1 = (c == 2) ? 8'h77 : 8'h00;
      @(negedge clk);
      check($sformatf("s_rd_pad_t_c%0d", c), 32'(pt1), 32'hFF);
      check($sformatf("s_rd_rsp_valid_c%0d", c), 32'(rv1), 32'(c == 3));
      check($sformatf("s_rd_rsp_write_c%0d", c), 32'(rw1), 32'd0);
      check($sformatf("s_rd_rdata_c%0d", c), 32'(rd1), (c >= 3) ? 32'h77 : 32'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
